// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the multi-channel clock divider.
// Imported by clk_div_chan and clk_div_multi.
package clk_div_pkg;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } div_mode_t;

    localparam int DEF_CNT_W        = 27;
    localparam int DEF_HALF_50M_1HZ = 25000000;

    function automatic logic [31:0] clamp_half(input logic [31:0] h);
        return (h == 32'd0) ? 32'd1 : h;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, shadow/active period and mode, registered outputs.
// Shadow values move to active only at a terminal count, or at once while disabled.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int DEF_HALF = DEF_HALF_50M_1HZ
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_half,
    input  div_mode_t        wr_mode,
    output logic             low_clock,
    output logic             tick
);

    localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(DEF_HALF);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_half_q, act_half_d;
    logic [CNT_W-1:0] sh_half_q, sh_half_d;
    div_mode_t        mode_q, mode_d;
    div_mode_t        sh_mode_q, sh_mode_d;
    logic             low_q, low_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] new_half;
    logic             term;

    assign new_half = CNT_W'(clamp_half(32'(wr_half)));
    assign term     = (cnt_q == act_half_q - CNT_W'(1));

    always_comb begin
        cnt_d      = cnt_q;
        act_half_d = act_half_q;
        sh_half_d  = sh_half_q;
        mode_d     = mode_q;
        sh_mode_d  = sh_mode_q;
        low_d      = low_q;
        tick_d     = 1'b0;

        if (wr_en) begin
            sh_half_d = new_half;
            sh_mode_d = wr_mode;
        end

        if (!en) begin
            if (wr_en) begin
                act_half_d = new_half;
                mode_d     = wr_mode;
                cnt_d      = '0;
            end
        end else if (term) begin
            cnt_d      = '0;
            tick_d     = 1'b1;
            act_half_d = sh_half_d;
            mode_d     = sh_mode_d;
            // leaving PULSE for TOGGLE starts the square wave low
            if (mode_q == MODE_TOGGLE) begin
                low_d = ~low_q;
            end else begin
                low_d = (sh_mode_d == MODE_PULSE);
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (mode_q == MODE_PULSE) begin
                low_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            act_half_q <= RST_HALF;
            sh_half_q  <= RST_HALF;
            mode_q     <= MODE_TOGGLE;
            sh_mode_q  <= MODE_TOGGLE;
            low_q      <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            act_half_q <= act_half_d;
            sh_half_q  <= sh_half_d;
            mode_q     <= mode_d;
            sh_mode_q  <= sh_mode_d;
            low_q      <= low_d;
            tick_q     <= tick_d;
        end
    end

    assign low_clock = low_q;
    assign tick      = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider / tick generator.
// Top holds the config decode and the ack/err registers only.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int DEF_HALF = DEF_HALF_50M_1HZ,
    parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              speed_clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] enable,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    input  logic              cfg_mode,
    output logic              cfg_ack,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] low_clock,
    output logic [NUM_CH-1:0] tick
);

    logic [31:0]       ch_ext;
    logic              ch_bad;
    logic [NUM_CH-1:0] ch_we;
    logic              ack_q, ack_d;
    logic              err_q, err_d;

    assign ch_ext = 32'(cfg_ch);
    assign ch_bad = (ch_ext >= 32'(NUM_CH));

    always_comb begin
        ack_d = cfg_we;
        err_d = cfg_we & ch_bad;
    end

    always_ff @(posedge speed_clock or posedge reset) begin
        if (reset) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
            err_q <= err_d;
        end
    end

    assign cfg_ack = ack_q;
    assign cfg_err = err_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch_we[i] = cfg_we & (ch_ext == 32'(i));

        clk_div_chan #(
            .CNT_W    (CNT_W),
            .DEF_HALF (DEF_HALF)
        ) u_chan (
            .clk       (speed_clock),
            .rst       (reset),
            .en        (enable[i]),
            .wr_en     (ch_we[i]),
            .wr_half   (cfg_half),
            .wr_mode   (div_mode_t'(cfg_mode)),
            .low_clock (low_clock[i]),
            .tick      (tick[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi with NUM_CH=4, CNT_W=8, DEF_HALF=4.
// Outputs are sampled on the falling edge; "after edge k" is edge k since reset release.
module tb_clk_div_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] en = 4'hF;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_ch = '0;
    logic [7:0] cfg_half = '0;
    logic       cfg_mode = 1'b0;
    logic       cfg_ack;
    logic       cfg_err;
    logic [3:0] low_clock;
    logic [3:0] tick;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    clk_div_multi #(
        .NUM_CH   (4),
        .CNT_W    (8),
        .DEF_HALF (4),
        .CH_W     (3)
    ) dut (
        .speed_clock (clk),
        .reset       (rst),
        .enable      (en),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_half    (cfg_half),
        .cfg_mode    (cfg_mode),
        .cfg_ack     (cfg_ack),
        .cfg_err     (cfg_err),
        .low_clock   (low_clock),
        .tick        (tick)
    );

    task automatic do_release();
        @(negedge clk);
        rst = 1'b1;
        cfg_we = 1'b0;
        en = 4'hF;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 4'hF;
        repeat (3) @(negedge clk);
        total++;
        if (low_clock !== 4'h0) begin
            bad++;
            $display("FAIL reset_low got=%h exp=0", low_clock);
        end
        total++;
        if (tick !== 4'h0) begin
            bad++;
            $display("FAIL reset_tick got=%h exp=0", tick);
        end
        total++;
        if (cfg_ack !== 1'b0) begin
            bad++;
            $display("FAIL reset_ack got=%b exp=0", cfg_ack);
        end
        total++;
        if (cfg_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_err got=%b exp=0", cfg_err);
        end
    endtask

    task automatic test_toggle();
        logic [3:0] el, et;
        do_release();
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            et = (k % 4 == 0) ? 4'hF : 4'h0;
            el = ((k / 4) % 2 == 1) ? 4'hF : 4'h0;
            total++;
            if (low_clock !== el) begin
                bad++;
                $display("FAIL toggle_low k=%0d got=%h exp=%h", k, low_clock, el);
            end
            total++;
            if (tick !== et) begin
                bad++;
                $display("FAIL toggle_tick k=%0d got=%h exp=%h", k, tick, et);
            end
        end
    endtask

    task automatic test_write_pulse();
        logic el, et;
        do_release();
        for (int k = 1; k <= 12; k++) begin
            cfg_we = (k == 5);
            cfg_ch = 3'd1;
            cfg_half = 8'd2;
            cfg_mode = 1'b1;
            @(negedge clk);
            if (k < 8) begin
                el = (k >= 4);
                et = (k == 4);
            end else begin
                et = (k % 2 == 0);
                el = (k == 8) ? 1'b0 : et;
            end
            total++;
            if ({low_clock[1], tick[1]} !== {el, et}) begin
                bad++;
                $display("FAIL pulse_ch1 k=%0d got=%b%b exp=%b%b",
                         k, low_clock[1], tick[1], el, et);
            end
            if (k == 5 || k == 6) begin
                total++;
                if ({cfg_ack, cfg_err} !== {k == 5, 1'b0}) begin
                    bad++;
                    $display("FAIL pulse_ack k=%0d got=%b%b exp=%b0",
                             k, cfg_ack, cfg_err, k == 5);
                end
            end
        end
        cfg_we = 1'b0;
    endtask

    task automatic test_half_zero();
        logic el, et;
        do_release();
        for (int k = 1; k <= 9; k++) begin
            cfg_we = (k == 2);
            cfg_ch = 3'd2;
            cfg_half = 8'd0;
            cfg_mode = 1'b0;
            @(negedge clk);
            et = (k >= 4);
            el = (k >= 4) && (k % 2 == 0);
            total++;
            if ({low_clock[2], tick[2]} !== {el, et}) begin
                bad++;
                $display("FAIL half0_ch2 k=%0d got=%b%b exp=%b%b",
                         k, low_clock[2], tick[2], el, et);
            end
        end
        cfg_we = 1'b0;
    endtask

    task automatic test_enable_hold();
        logic el, et;
        do_release();
        for (int k = 1; k <= 14; k++) begin
            en = (k >= 3 && k <= 12) ? 4'h7 : 4'hF;
            @(negedge clk);
            el = (k >= 14);
            et = (k == 14);
            if (k >= 3) begin
                total++;
                if ({low_clock[3], tick[3]} !== {el, et}) begin
                    bad++;
                    $display("FAIL hold_ch3 k=%0d got=%b%b exp=%b%b",
                             k, low_clock[3], tick[3], el, et);
                end
            end
            if (k == 12) begin
                total++;
                if (tick[2:0] !== 3'h7) begin
                    bad++;
                    $display("FAIL hold_others k=%0d got=%h exp=7", k, tick[2:0]);
                end
            end
        end
        en = 4'hF;
    endtask

    task automatic test_bad_ch_back_to_back();
        logic el, et;
        do_release();
        for (int k = 1; k <= 10; k++) begin
            cfg_we = (k <= 3);
            cfg_ch = (k == 1) ? 3'd5 : 3'd0;
            cfg_half = (k == 3) ? 8'd3 : 8'd6;
            cfg_mode = 1'b0;
            @(negedge clk);
            if (k <= 4) begin
                total++;
                if ({cfg_ack, cfg_err} !== {k <= 3, k == 1}) begin
                    bad++;
                    $display("FAIL b2b_ackerr k=%0d got=%b%b exp=%b%b",
                             k, cfg_ack, cfg_err, k <= 3, k == 1);
                end
            end
            if (k >= 4) begin
                et = (k == 4 || k == 7 || k == 10);
                el = (k <= 6 || k == 10);
                total++;
                if ({low_clock[0], tick[0]} !== {el, et}) begin
                    bad++;
                    $display("FAIL b2b_ch0 k=%0d got=%b%b exp=%b%b",
                             k, low_clock[0], tick[0], el, et);
                end
            end
            if (k == 4) begin
                total++;
                if ({low_clock[3:1], tick[3:1]} !== 6'b111111) begin
                    bad++;
                    $display("FAIL b2b_untouched got=%b%b exp=111111",
                             low_clock[3:1], tick[3:1]);
                end
            end
        end
        cfg_we = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic el, et;
        do_release();
        for (int k = 1; k <= 7; k++) begin
            cfg_we = (k == 7);
            cfg_ch = 3'd0;
            cfg_half = 8'd2;
            cfg_mode = 1'b0;
            @(negedge clk);
        end
        cfg_we = 1'b0;
        total++;
        if ({low_clock[0], cfg_ack} !== 2'b11) begin
            bad++;
            $display("FAIL mid_pre got=%b%b exp=11", low_clock[0], cfg_ack);
        end
        #1;
        rst = 1'b1;
        #1;
        total++;
        if ({low_clock, tick, cfg_ack} !== 9'b0) begin
            bad++;
            $display("FAIL mid_async got=%h %h %b exp=0 0 0",
                     low_clock, tick, cfg_ack);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            el = (k >= 4);
            et = (k == 4);
            total++;
            if ({low_clock[0], tick[0]} !== {el, et}) begin
                bad++;
                $display("FAIL mid_after k=%0d got=%b%b exp=%b%b",
                         k, low_clock[0], tick[0], el, et);
            end
        end
    endtask

    initial begin
        test_reset();
        test_toggle();
        test_write_pulse();
        test_half_zero();
        test_enable_hold();
        test_bad_ch_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
